// File: rtl/vga_screen_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_screen_arbiter
// Purpose  : Starts one full-screen painter (START/MAP/WIN/LOSE ROM painters,
//            160x120x9b) by releasing its reset. Forwards that painter's
//            pixel stream to the single VGA adapter port and returns the
//            painter to reset when it reports done. Reports frame completion
//            and pixel-count errors.
// Ports    : clk, resetn          - clock, synchronous active-low reset
//            req_valid/req_sel/   - screen request handshake (accepted when
//            req_ready              req_valid && req_ready)
//            src_resetn/src_done  - per-painter reset release / done flag
//            src_x/src_y/         - packed per-painter pixel buses
//            src_colour
//            vga_x/vga_y/         - muxed pixel toward the VGA adapter
//            vga_colour/vga_plot
//            busy, frame_done,    - status: not idle, 1-cycle completion
//            err                    pulse, sticky error flag
// Revision : 1.0 - initial release
// ============================================================================
module vga_screen_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int W       = 160,
  parameter int H       = 120,
  parameter int SLACK   = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  input  logic [SEL_W-1:0]       req_sel,
  output logic                   req_ready,
  output logic [NUM_SRC-1:0]     src_resetn,
  input  logic [NUM_SRC-1:0]     src_done,
  input  logic [8*NUM_SRC-1:0]   src_x,
  input  logic [7*NUM_SRC-1:0]   src_y,
  input  logic [9*NUM_SRC-1:0]   src_colour,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [8:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err
);

  localparam int                 CNT_W     = 15;
  localparam logic [CNT_W-1:0]   FRAME_PIX = CNT_W'(W * H);
  localparam logic [CNT_W-1:0]   ABORT_PIX = CNT_W'(W * H + SLACK);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_DRAW   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t               state;
  logic [SEL_W-1:0]     sel;
  logic [CNT_W-1:0]     pix_cnt;
  logic                 launch_cnt;
  logic                 bad_pulse;

  // Next-state values from the combinational process
  state_t               state_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic [CNT_W-1:0]     pix_nxt;
  logic                 launch_nxt;
  logic                 bad_nxt;
  logic                 err_nxt;
  logic [NUM_SRC-1:0]   src_resetn_nxt;

  // --------------------------------------------------------------------------
  // Unpack the per-source buses into arrays so the selected source can be
  // picked with a plain array index.
  // --------------------------------------------------------------------------
  logic [7:0] x_arr      [NUM_SRC];
  logic [6:0] y_arr      [NUM_SRC];
  logic [8:0] colour_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
    assign x_arr[i]      = src_x[8*i +: 8];
    assign y_arr[i]      = src_y[7*i +: 7];
    assign colour_arr[i] = src_colour[9*i +: 9];
  end

  // --------------------------------------------------------------------------
  // Pixel counter helpers
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]     pix_inc;     // saturating increment
  logic [CNT_W:0]       pix_plus1;   // exact count including this cycle
  logic                 req_in_range;

  assign pix_inc      = (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + 1'b1;
  assign pix_plus1    = {1'b0, pix_cnt} + 1'b1;
  assign req_in_range = (int'(req_sel) < NUM_SRC);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      sel        <= '0;
      pix_cnt    <= '0;
      launch_cnt <= 1'b0;
      bad_pulse  <= 1'b0;
      err        <= 1'b0;
      src_resetn <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      pix_cnt    <= pix_nxt;
      launch_cnt <= launch_nxt;
      bad_pulse  <= bad_nxt;
      err        <= err_nxt;
      src_resetn <= src_resetn_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    pix_nxt        = pix_cnt;
    launch_nxt     = launch_cnt;
    bad_nxt        = 1'b0;
    err_nxt        = err;
    src_resetn_nxt = src_resetn;

    req_ready      = 1'b0;
    busy           = 1'b1;
    vga_plot       = 1'b0;
    vga_x          = '0;
    vga_y          = '0;
    vga_colour     = '0;
    // A rejected out-of-range request still produces a completion pulse
    frame_done     = bad_pulse;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (req_in_range) begin
            sel_nxt                 = req_sel;
            err_nxt                 = 1'b0;
            pix_nxt                 = '0;
            launch_nxt              = 1'b0;
            src_resetn_nxt          = '0;
            src_resetn_nxt[req_sel] = 1'b1;
            state_nxt               = S_LAUNCH;
          end else begin
            err_nxt = 1'b1;
            bad_nxt = 1'b1;
          end
        end
      end

      // Two cycles: the painter needs one cycle to leave reset and one more
      // for its registered ROM/coordinate stage before pixel 0 is on its bus.
      S_LAUNCH: begin
        launch_nxt = 1'b1;
        if (launch_cnt) begin
          state_nxt = S_DRAW;
        end
      end

      S_DRAW: begin
        vga_plot   = 1'b1;
        vga_x      = x_arr[sel];
        vga_y      = y_arr[sel];
        vga_colour = colour_arr[sel];
        pix_nxt    = pix_inc;
        if (src_done[sel]) begin
          // Done marks the last pixel, which is plotted in this same cycle
          src_resetn_nxt = '0;
          err_nxt        = (pix_plus1 != {1'b0, FRAME_PIX});
          state_nxt      = S_DONE;
        end else if (pix_inc >= ABORT_PIX) begin
          // Painter overran the frame by more than the allowed slack
          src_resetn_nxt = '0;
          err_nxt        = 1'b1;
          state_nxt      = S_DONE;
        end
      end

      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_screen_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_screen_arbiter
// Purpose  : Self-checking bench for vga_screen_arbiter. Painter models feed
//            the source buses; a scoreboard queue holds the expected pixel
//            stream and frame result of each accepted request, and a monitor
//            compares every plotted pixel and every frame_done against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_screen_arbiter;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;
  localparam int W       = 160;
  localparam int H       = 120;
  localparam int SLACK   = 64;
  localparam int FRAME   = W * H;
  localparam int ABORT   = W * H + SLACK;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 req_valid = 1'b0;
  logic [SEL_W-1:0]     req_sel = '0;
  logic                 req_ready;
  logic [NUM_SRC-1:0]   src_resetn;
  logic [NUM_SRC-1:0]   src_done;
  logic [8*NUM_SRC-1:0] src_x;
  logic [7*NUM_SRC-1:0] src_y;
  logic [9*NUM_SRC-1:0] src_colour;
  logic [7:0]           vga_x;
  logic [6:0]           vga_y;
  logic [8:0]           vga_colour;
  logic                 vga_plot;
  logic                 busy;
  logic                 frame_done;
  logic                 err;

  always #5 clk = ~clk;

  vga_screen_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W),
    .W       (W),
    .H       (H),
    .SLACK   (SLACK)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .src_resetn (src_resetn),
    .src_done   (src_done),
    .src_x      (src_x),
    .src_y      (src_y),
    .src_colour (src_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  // --------------------------------------------------------------------------
  // Pixel content of painter src at raster position p
  // --------------------------------------------------------------------------
  function automatic logic [7:0] pix_x(input int p);
    return 8'(p % W);
  endfunction

  function automatic logic [6:0] pix_y(input int p);
    return 7'((p / W) % H);
  endfunction

  function automatic logic [8:0] pix_colour(input int src, input int p);
    return 9'((p * 5 + src * 97) ^ (p >> 3));
  endfunction

  // --------------------------------------------------------------------------
  // Painter models: age counts edges since reset release; raster position is
  // age-2 (one start cycle plus one registered ROM stage). frame_len=0 means
  // the painter never raises done.
  // --------------------------------------------------------------------------
  int                 age       [NUM_SRC];
  int                 frame_len [NUM_SRC];
  logic [NUM_SRC-1:0] spur_done = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_resetn[i] !== 1'b1) age[i] <= 0;
      else                        age[i] <= age[i] + 1;
    end
  end

  always_comb begin
    src_x      = '0;
    src_y      = '0;
    src_colour = '0;
    src_done   = spur_done;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (age[i] >= 2) begin
        src_x[8*i +: 8]      = pix_x(age[i] - 2);
        src_y[7*i +: 7]      = pix_y(age[i] - 2);
        src_colour[9*i +: 9] = pix_colour(i, age[i] - 2);
        if (frame_len[i] != 0 && (age[i] - 2) == frame_len[i] - 1)
          src_done[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    bit         is_end;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
    bit         err;
  } exp_t;

  exp_t expq [$];
  int   latq [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  bit in_frame  = 1'b0;
  int pix_bad   = 0;
  int first_bad = -1;
  int extra     = 0;
  int pix_idx   = 0;
  int idle_nz   = 0;

  always @(negedge clk) begin
    exp_t e;
    int   missing;
    int   a;
    if (resetn !== 1'b1) begin
      in_frame  = 1'b0;
      pix_bad   = 0;
      first_bad = -1;
      extra     = 0;
      pix_idx   = 0;
    end else begin
      if (vga_plot === 1'b1) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          if (latq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL first_plot_latency: plot with no accepted request (t=%0t)", $time);
          end else begin
            a = latq.pop_front();
            check("first_plot_latency", cyc - a, 2);
          end
        end
        if (expq.size() > 0 && !expq[0].is_end) begin
          e = expq.pop_front();
          if ({vga_x, vga_y, vga_colour} !== {e.x, e.y, e.c}) begin
            if (pix_bad == 0) first_bad = pix_idx;
            pix_bad++;
          end
        end else begin
          extra++;
        end
        pix_idx++;
      end else if ({vga_x, vga_y, vga_colour} != '0) begin
        idle_nz++;
      end

      if (frame_done === 1'b1) begin
        missing = 0;
        while (expq.size() > 0 && !expq[0].is_end) begin
          e = expq.pop_front();
          missing++;
        end
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_end: unexpected frame_done after %0d plots (t=%0t)", pix_idx, $time);
        end else begin
          e = expq.pop_front();
          check("plot_count_missing", missing, 0);
          check("plot_count_extra", extra, 0);
          checks++;
          if (pix_bad != 0) begin
            failures++;
            $display("FAIL frame_pixels: actual %0d wrong pixels (first at index %0d), required 0",
                     pix_bad, first_bad);
          end
          check("frame_err", err, e.err);
          check("src_resetn_after_frame", src_resetn, 0);
          check("plot_low_on_frame_done", vga_plot, 0);
        end
        in_frame  = 1'b0;
        pix_bad   = 0;
        first_bad = -1;
        extra     = 0;
        pix_idx   = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus tasks (called at a negedge)
  // --------------------------------------------------------------------------
  task automatic start_frame(input int sel, input int len);
    exp_t e;
    int   n;
    frame_len[sel] = len;
    n = (len == 0 || len > ABORT) ? ABORT : len;
    for (int p = 0; p < n; p++) begin
      e.is_end = 1'b0;
      e.x      = pix_x(p);
      e.y      = pix_y(p);
      e.c      = pix_colour(sel, p);
      e.err    = 1'b0;
      expq.push_back(e);
    end
    e.is_end = 1'b1;
    e.x      = '0;
    e.y      = '0;
    e.c      = '0;
    e.err    = (n != FRAME);
    expq.push_back(e);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_sel   = SEL_W'(sel);
    @(negedge clk);
    req_valid = 1'b0;
    latq.push_back(cyc);
    check("busy_after_accept", busy, 1);
    check("err_clear_on_accept", err, 0);
    check("src_released", src_resetn, 32'(1) << sel);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_done !== 1'b1 && n < ABORT + 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", frame_done, 1);
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int s;
    for (int i = 0; i < NUM_SRC; i++) frame_len[i] = FRAME;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_src_resetn", src_resetn, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_err", err, 0);
    check("reset_plot", vga_plot, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame
    s = $urandom_range(0, NUM_SRC - 1);
    start_frame(s, FRAME);
    repeat (5002) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midframe_reset_busy", busy, 0);
    check("midframe_reset_plot", vga_plot, 0);
    check("midframe_reset_src_resetn", src_resetn, 0);
    expq.delete();
    latq.delete();
    resetn = 1'b1;
    @(negedge clk);

    // Full nominal frame from source 3
    start_frame(3, FRAME);
    wait_frame();
    check("err_after_good_frame", err, 0);

    // Early done: short frame sets sticky err
    s = $urandom_range(0, NUM_SRC - 1);
    start_frame(s, $urandom_range(1000, 3000));
    wait_frame();
    check("err_sticky_short", err, 1);

    // Source 0 full frame with an ignored mid-frame request and spurious done
    start_frame(0, FRAME);
    repeat (3000) @(negedge clk);
    req_valid = 1'b1;
    req_sel   = SEL_W'(1);
    check("req_ready_while_busy", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_req_ignored_src_resetn", src_resetn, 4'b0001);
    spur_done = 4'b0100;
    repeat (50) @(negedge clk);
    check("spurious_done_ignored_busy", busy, 1);
    spur_done = '0;
    wait_frame();
    check("err_after_clean_frame", err, 0);

    // Painter that never finishes: timeout abort
    s = $urandom_range(0, NUM_SRC - 1);
    start_frame(s, 0);
    wait_frame();
    check("err_sticky_timeout", err, 1);

    // Single-pixel frame and a few short random frames
    start_frame($urandom_range(0, NUM_SRC - 1), 1);
    wait_frame();
    for (int k = 0; k < 3; k++) begin
      start_frame($urandom_range(0, NUM_SRC - 1), $urandom_range(2, 400));
      wait_frame();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", expq.size(), 0);
    check("latency_queue_drained", latq.size(), 0);
    check("vga_bus_zero_outside_draw", idle_nz, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
